wb_write_queue: RTL

- Write-port initiator for the 32x32 CPU register file.
- Accepts writeback requests from execute/memory units over a valid/ready handshake and buffers them in an in-order FIFO.
- Drives the register file write port (RegWrite/RDaddr/RDdata) with at most one write per cycle.
- Exports a pending-destination mask for decode stall logic, plus an optional bypass lookup.

---
 rtl/wb_pkg.sv | 11 +
 rtl/wb_fifo.sv | 42 ++++
 rtl/wb_write_queue.sv | 87 ++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and request type for the register-file writeback queue
package wb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order request storage; entries are exported oldest-first with per-entry valid flags
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  wb_req_t                      din_i,
  output wb_req_t                      ent_o [DEPTH],
  output logic [DEPTH-1:0]             vld_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  wb_req_t r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (push_i) r_wr <= r_wr + PW'(1);
      if (pop_i) r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(push_i) - CW'(pop_i);
    end
  always_ff @(posedge clk_i)
    if (push_i) r_mem[r_wr] <= din_i;
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_o[i] = r_mem[r_rd + PW'(i)];
    assign vld_o[i] = CW'(i) < r_cnt;
  end
  assign count_o = r_cnt;
  assign full_o = r_cnt == CW'(DEPTH);
  assign empty_o = r_cnt == '0;
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: buffered register-file writeback initiator; define WB_BYPASS_EN for the q_hit_o/q_data_o bypass lookup
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [ADDR_W-1:0]           req_addr_i,
  input  logic [DATA_W-1:0]           req_data_i,
  input  logic                        drain_en_i,
  output logic                        RegWrite_o,
  output logic [ADDR_W-1:0]           RDaddr_o,
  output logic [DATA_W-1:0]           RDdata_o,
  output logic [31:0]                 pend_mask_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o,
  input  logic [ADDR_W-1:0]           q_addr_i,
  output logic                        q_hit_o,
  output logic [DATA_W-1:0]           q_data_o
);
  wb_req_t w_ent [DEPTH];
  wb_req_t w_din;
  logic [DEPTH-1:0] w_vld;
  logic w_full, w_empty, w_push, w_pop;
  logic r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [NUM_REGS-1:0] w_pend;
  assign req_ready_o = !w_full;
  // writes to $0 complete the handshake but are dropped here
  assign w_push = req_valid_i && req_ready_o && req_addr_i != ADDR_W'(ZERO_REG);
  assign w_pop = drain_en_i && !w_empty;
  assign w_din = {req_addr_i, req_data_i};
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (w_din),
    .ent_o   (w_ent),
    .vld_o   (w_vld),
    .count_o (count_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_we <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_pop;
      if (w_pop) begin
        r_addr <= w_ent[0].addr;
        r_data <= w_ent[0].data;
      end
    end
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) if (w_vld[i]) w_pend[w_ent[i].addr] = 1'b1;
    if (r_we) w_pend[r_addr] = 1'b1;
    w_pend[0] = 1'b0;
  end
  assign RegWrite_o = r_we;
  assign RDaddr_o = r_addr;
  assign RDdata_o = r_data;
  assign pend_mask_o = w_pend;
`ifdef WB_BYPASS_EN
  logic [DATA_W-1:0] w_qdata;
  // entries are oldest-first, so the last match is the youngest
  always_comb begin
    w_qdata = (r_we && r_addr == q_addr_i) ? r_data : '0;
    for (int i = 0; i < DEPTH; i++) if (w_vld[i] && w_ent[i].addr == q_addr_i) w_qdata = w_ent[i].data;
  end
  assign q_hit_o = q_addr_i != ADDR_W'(ZERO_REG) && w_pend[q_addr_i];
  assign q_data_o = w_qdata;
`else
  logic w_unused_q;
  assign w_unused_q = ^q_addr_i;
  assign q_hit_o = 1'b0;
  assign q_data_o = '0;
`endif
endmodule
